// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - issue/result bundle between control unit and muldiv_unit
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (output start, op, a, b, mthi, mtlo, input hi, lo, busy, done);
  modport slave  (input start, op, a, b, mthi, mtlo, output hi, lo, busy, done);
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU into HI/LO with MTHI/MTLO
// MULDIV_FAST_MUL_EN: single-cycle combinational multiply; division stays iterative
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam int            DW   = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t state_q, state_d;

  logic             div_q;
  logic             neg_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] a_q;
  logic [DW-1:0]    acc_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;

  // Operand magnitudes; unsigned ops pass straight through
  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign sa    = ~bus.op[0] & bus.a[WIDTH-1];
  assign sb    = ~bus.op[0] & bus.b[WIDTH-1];
  assign mag_a = sa ? -bus.a : bus.a;
  assign mag_b = sb ? -bus.b : bus.b;

  logic [DW-1:0] iter_init, acc_init;
  logic          fast_mul;
  assign iter_init = bus.op[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};

`ifdef MULDIV_FAST_MUL_EN
  assign fast_mul = ~bus.op[1];
  assign acc_init = fast_mul ? DW'(mag_a) * DW'(mag_b) : iter_init;
`else
  assign fast_mul = 1'b0;
  assign acc_init = iter_init;
`endif

  // Shift-add: acc = {partial high half, remaining multiplier bits}
  logic [WIDTH:0]  mul_sum;
  logic [DW-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring division: acc = {remainder, dividend bits shifting into quotient}
  logic [WIDTH:0]   rem_sh, diff;
  logic             ge;
  logic [DW-1:0]    div_next;
  logic             unused_diff_msb;
  assign rem_sh          = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]};
  assign ge              = rem_sh >= {1'b0, opnd_q};
  assign diff            = rem_sh - {1'b0, opnd_q};
  assign unused_diff_msb = diff[WIDTH];
  assign div_next = ge ? {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                       : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

  logic [DW-1:0]    res_mul;
  logic [WIDTH-1:0] fin_hi, fin_lo;
  assign res_mul = neg_q ? -acc_q : acc_q;

  always_comb begin
    fin_hi = res_mul[DW-1:WIDTH];
    fin_lo = res_mul[WIDTH-1:0];
    if (div_q) begin
      if (opnd_q == '0) begin
        fin_hi = a_q;
        fin_lo = '1;
      end else begin
        fin_lo = neg_q     ? -acc_q[WIDTH-1:0]  : acc_q[WIDTH-1:0];
        fin_hi = neg_rem_q ? -acc_q[DW-1:WIDTH] : acc_q[DW-1:WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = fast_mul ? FINISH : CALC;
      CALC:    if (cnt_q == LAST) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= '0;
      a_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            div_q     <= bus.op[1];
            neg_q     <= sa ^ sb;
            neg_rem_q <= sa;
            opnd_q    <= bus.op[1] ? mag_b : mag_a;
            a_q       <= bus.a;
            acc_q     <= acc_init;
            cnt_q     <= '0;
          end else begin
            if (bus.mthi) hi_q <= bus.a;
            if (bus.mtlo) lo_q <= bus.a;
          end
        end
        CALC: begin
          acc_q <= div_q ? div_next : mul_next;
          cnt_q <= cnt_q + 1'b1;
        end
        FINISH: begin
          hi_q   <= fin_hi;
          lo_q   <= fin_lo;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit against an arithmetic model
module tb_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] model_hi, model_lo;

  muldiv_unit_if #(.WIDTH(32)) bus ();
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Architectural result {hi, lo} from plain 64-bit arithmetic
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      2'b00: begin p = sa * sb; return p; end
      2'b01: begin p = ua * ub; return p; end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        p = ua / ub;
        ua = ua % ub;
        return {ua[31:0], p[31:0]};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit with_mthi);
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    bus.mthi  = with_mthi;
    bus.mtlo  = 1'b0;
  endtask

  // Called just after issue(); returns in the done cycle with inputs quiet
  task automatic wait_done(input string tag, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y, input bit scribble);
    logic [63:0] exp;
    int          exp_lat, cyc, busy_cyc;
    bit          held;
    exp      = ref_model(o, x, y);
    exp_lat  = (FAST && !o[1]) ? 1 : 33;
    cyc      = 0;
    busy_cyc = 0;
    held     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    while (!bus.done && cyc < 200) begin
      if (bus.busy) busy_cyc++;
      if (bus.hi !== model_hi || bus.lo !== model_lo) held = 1'b0;
      if (scribble) begin
        bus.start = 1'(($urandom));
        bus.mthi  = 1'(($urandom));
        bus.mtlo  = 1'(($urandom));
        bus.op    = 2'(($urandom));
        bus.a     = $urandom;
        bus.b     = $urandom;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.start = 1'b0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_lat));
    check({tag, "_busy_at_done"}, 64'(bus.busy), 64'h0);
    check({tag, "_hilo_held"}, 64'(held), 64'h1);
    check({tag, "_hi"}, 64'(bus.hi), 64'(exp[63:32]));
    check({tag, "_lo"}, 64'(bus.lo), 64'(exp[31:0]));
    model_hi = exp[63:32];
    model_lo = exp[31:0];
  endtask

  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input bit scribble);
    issue(o, x, y, 1'b0);
    wait_done(tag, o, x, y, scribble);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 64'(bus.done), 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  o;
    logic [31:0] x, y;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
    model_hi = '0;
    model_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hi", 64'(bus.hi), 64'h0);
    check("reset_lo", 64'(bus.lo), 64'h0);
    check("reset_busy", 64'(bus.busy), 64'h0);
    check("reset_done", 64'(bus.done), 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'h7, 1'b0);
    check("mult_neg3x7_hi_const", 64'(bus.hi), 64'hFFFF_FFFF);
    check("mult_neg3x7_lo_const", 64'(bus.lo), 64'hFFFF_FFEB);
    run("div_neg7_2", 2'b10, 32'hFFFF_FFF9, 32'h2, 1'b0);
    check("div_neg7_2_lo_const", 64'(bus.lo), 64'hFFFF_FFFD);
    run("divu_by0", 2'b11, 32'h7, 32'h0, 1'b0);
    check("divu_by0_hi_const", 64'(bus.hi), 64'h7);
    run("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_min_m1_lo_const", 64'(bus.lo), 64'h8000_0000);
    run("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_hi_const", 64'(bus.hi), 64'hFFFF_FFFE);
    run("div_by0_signed", 2'b10, 32'h8000_0005, 32'h0, 1'b0);

    // Writes and starts while busy must be ignored
    run("busy_scribble_mul", 2'b00, 32'h0001_2345, 32'hFFFF_0003, 1'b1);
    run("busy_scribble_div", 2'b10, 32'hF000_1234, 32'h0000_0077, 1'b1);

    bus.a = 32'h1234; bus.mthi = 1'b1;
    @(posedge clk);
    #1;
    bus.mthi = 1'b0;
    check("mthi_hi", 64'(bus.hi), 64'h1234);
    check("mthi_lo_kept", 64'(bus.lo), 64'(model_lo));
    check("mthi_done", 64'(bus.done), 64'h0);
    bus.a = 32'h5678; bus.mtlo = 1'b1;
    @(posedge clk);
    #1;
    bus.mtlo = 1'b0;
    check("mtlo_lo", 64'(bus.lo), 64'h5678);
    check("mtlo_hi_kept", 64'(bus.hi), 64'h1234);
    x = $urandom;
    bus.a = x; bus.mthi = 1'b1; bus.mtlo = 1'b1;
    @(posedge clk);
    #1;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    check("mthilo_hi", 64'(bus.hi), 64'(x));
    check("mthilo_lo", 64'(bus.lo), 64'(x));
    model_hi = x;
    model_lo = x;

    // start wins over a simultaneous mthi
    issue(2'b01, 32'h0000_1000, 32'h0003_0000, 1'b1);
    wait_done("start_mthi", 2'b01, 32'h0000_1000, 32'h0003_0000, 1'b0);

    // Back-to-back: new start in the done cycle
    issue(2'b11, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
    wait_done("b2b_first", 2'b11, 32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
    issue(2'b10, 32'h8765_4321, 32'hFFFF_FF00, 1'b0);
    wait_done("b2b_second", 2'b10, 32'h8765_4321, 32'hFFFF_FF00, 1'b0);
    issue(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    wait_done("b2b_third", 2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a DIVU
    issue(2'b11, 32'hFFFF_FFF0, 32'h0000_0003, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_hi", 64'(bus.hi), 64'h0);
    check("rst_mid_lo", 64'(bus.lo), 64'h0);
    check("rst_mid_busy", 64'(bus.busy), 64'h0);
    check("rst_mid_done", 64'(bus.done), 64'h0);
    model_hi = '0;
    model_lo = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_after_busy", 64'(bus.busy), 64'h0);
    run("after_reset", 2'b11, 32'h0000_0064, 32'h0000_0007, 1'b0);

    for (int i = 0; i < 24; i++) begin
      o = 2'(($urandom));
      x = pick();
      y = pick();
      run($sformatf("rand%0d_op%0d", i, o), o, x, y, 1'(i % 3 == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
